// File: rtl/pulse_wave_gen.sv
// pulse_wave_gen: gated pulse-wave sample source built on a phase accumulator.
// The accumulator advances by freq on each sample strobe. The output is HI while the top
// byte of the phase is below pw, and LO otherwise. When gate drops, playback continues
// until the phase wraps, so the stream stops without a click.
module pulse_wave_gen #(
    parameter int ACC_WIDTH  = 16,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_en,
    input  logic                  gate,
    input  logic [ACC_WIDTH-1:0]  freq,
    input  logic [7:0]            pw,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  active
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    localparam logic [DATA_WIDTH-1:0] HI = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] LO = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    state_t state, state_nx;
    logic [ACC_WIDTH-1:0] acc, acc_sum, acc_nx;
    logic [DATA_WIDTH-1:0] dout_nx;
    logic carry;
    assign {carry, acc_sum} = {1'b0, acc} + {1'b0, freq};
    assign active = state != IDLE;
    // State, phase and sample advance only on strobes; valid mirrors the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= sample_en;
            if (sample_en) begin
                state <= state_nx;
                acc   <= acc_nx;
                dout  <= dout_nx;
            end
        end
    end
    // Next state: a stop request is honoured only at a phase wrap or with freq stalled.
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = gate ? RUN : IDLE;
            RUN:     state_nx = gate ? RUN : STOP;
            STOP:    state_nx = gate ? RUN : ((carry || freq == '0) ? IDLE : STOP);
            default: state_nx = IDLE;
        endcase
    end
    // Outputs: idle parks the phase and sample at zero; otherwise use the advanced phase.
    always_comb begin
        acc_nx  = (state_nx == IDLE) ? '0 : acc_sum;
        dout_nx = (state_nx == IDLE) ? '0 : ((acc_sum[ACC_WIDTH-1 -: 8] < pw) ? HI : LO);
    end
endmodule

// File: tb/tb_pulse_wave_gen.sv
// tb_pulse_wave_gen: scoreboard bench for pulse_wave_gen with a phase/level reference model.
module tb_pulse_wave_gen;
    logic        clk = 1'b0, rst = 1'b1, sample_en = 1'b0, gate = 1'b0;
    logic [15:0] freq = '0;
    logic [7:0]  pw = '0;
    logic [11:0] dout;
    logic        dout_valid, active;
    typedef struct { int d; bit a; } exp_t;
    exp_t q[$];
    int   errors = 0, checks = 0;
    int   last_d = 0;
    bit   last_a = 1'b0;
    bit   armed = 1'b0;
    int   phase = 0;
    int   mode = 0;

    pulse_wave_gen dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .gate(gate),
        .freq(freq), .pw(pw), .dout(dout), .dout_valid(dout_valid), .active(active)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Mode 0 = silent, 1 = playing, 2 = finishing the current period.
    task automatic model(bit g, int f, int p);
        int nxt, nm, d;
        bit wrap;
        exp_t e;
        nxt  = phase + f;
        wrap = nxt >= 65536;
        nxt  = nxt % 65536;
        if (mode == 0) nm = g ? 1 : 0;
        else if (mode == 1) nm = g ? 1 : 2;
        else nm = g ? 1 : ((wrap || f == 0) ? 0 : 2);
        if (nm == 0) begin
            phase = 0;
            d = 0;
        end else begin
            phase = nxt;
            d = ((nxt / 256) < p) ? 2047 : -2048;
        end
        mode = nm;
        e.d = d;
        e.a = nm != 0;
        q.push_back(e);
    endtask

    task automatic step(bit r, bit se, bit g, int f, int p);
        rst = r; sample_en = se; gate = g; freq = f[15:0]; pw = p[7:0];
        @(posedge clk);
        if (r) begin
            phase = 0; mode = 0; last_d = 0; last_a = 1'b0;
            q.delete();
        end else if (se) model(g, f, p);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            if (dout_valid) begin
                if (q.size() == 0) check("spurious_valid", 1, 0);
                else begin
                    e = q.pop_front();
                    check("dout", $signed(dout), e.d);
                    check("active", int'(active), int'(e.a));
                    last_d = e.d;
                    last_a = e.a;
                end
            end else begin
                if (q.size() != 0) begin
                    void'(q.pop_front());
                    check("missing_valid", 0, 1);
                end
                check("hold_dout", $signed(dout), last_d);
                check("hold_active", int'(active), int'(last_a));
            end
        end
    end

    initial begin
        int cnt, f, p;
        bit g;
        // Reset state
        step(1, 0, 0, 0, 0);
        armed = 1'b1;
        step(1, 0, 0, 0, 0);
        check("rst_dout", $signed(dout), 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_active", int'(active), 0);
        step(0, 0, 0, 0, 0);
        // 50% pulse, first sample at phase 0x0100
        step(0, 1, 1, 256, 128);
        check("first_sample", $signed(dout), 2047);
        check("first_active", int'(active), 1);
        for (int i = 0; i < 300; i++) step(0, 1, 1, 256, 128);
        // pw extremes
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(0, 1, 1, 256, 0);
            if ($signed(dout) != -2048) cnt++;
        end
        check("pw0_hi_count", cnt, 0);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(0, 1, 1, 256, 255);
            if ($signed(dout) == -2048) cnt++;
        end
        check("pw255_lo_count", cnt, 1);
        // Stop from phase 0x8000 completes at the wrap
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 128; i++) step(0, 1, 1, 256, 128);
        for (int i = 0; i < 127; i++) step(0, 1, 0, 256, 128);
        check("stop_still_active", int'(active), 1);
        step(0, 1, 0, 256, 128);
        check("stop_wrap_active", int'(active), 0);
        check("stop_wrap_dout", $signed(dout), 0);
        // Re-raise gate during stop
        for (int i = 0; i < 40; i++) step(0, 1, 1, 256, 100);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 256, 100);
        for (int i = 0; i < 60; i++) step(0, 1, 1, 256, 100);
        // freq=0 in run, then in stop, then mid-period freq change
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 100);
        step(0, 1, 0, 0, 100);
        step(0, 1, 0, 0, 100);
        check("freq0_stop_idle", int'(active), 0);
        for (int i = 0; i < 30; i++) step(0, 1, 1, 1000, 77);
        for (int i = 0; i < 30; i++) step(0, 1, 1, 3000, 77);
        // Sparse strobes, then reset mid-run
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 1, 2048, 60);
            for (int k = 0; k < 3; k++) step(0, 0, 1, 2048, 60);
        end
        step(1, 0, 1, 2048, 60);
        check("midrun_rst_dout", $signed(dout), 0);
        check("midrun_rst_active", int'(active), 0);
        // Randomized traffic
        f = 256; p = 128;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: f = 0;
                    1: f = $urandom_range(1, 255);
                    2: f = $urandom_range(0, 65535);
                    default: f = $urandom_range(256, 2048);
                endcase
                p = $urandom_range(0, 255);
            end
            g = $urandom_range(0, 9) != 0;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, g, f, p);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
